// File: rtl/instruction_cache_if.sv
// -----------------------------------------------------------------------------
// wishbone_if: Wishbone B4 style bus bundle shared by the instruction cache's
// processor-side and memory-side ports.
//
// Parameters
//   ADDR_W  byte address width
//   DATA_W  data width of this link (processor word or full cache line)
//
// Fields
//   cyc, stb, we, sel, tgd, addr   request, driven by the primary
//   dat_o_s, ack                   response, driven by the secondary
//   dat_i_p                        line data returned to a primary
//
// Modports
//   secondary  request inputs, dat_o_s/ack outputs (cache toward processor)
//   primary    request outputs, dat_i_p/ack inputs (cache toward memory)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface wishbone_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [DATA_W/8-1:0]   sel;
    logic                  tgd;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     dat_o_s;
    logic [DATA_W-1:0]     dat_i_p;
    logic                  ack;

    modport secondary (
        input  cyc, stb, we, sel, tgd, addr,
        output dat_o_s, ack
    );

    modport primary (
        output cyc, stb, we, sel, tgd, addr,
        input  dat_i_p, ack
    );
endinterface

// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache: direct-mapped, read-only instruction cache. Processor
// fetches arrive on wish_s; missing lines are refilled as one full-line
// transfer on wish_p. Hits respond 2 cycles after stb, misses stall until the
// refill is done. Tag/data arrays live in flops and are not reset.
//
// Ports
//   clock        system clock
//   reset_n      asynchronous reset, active low
//   invalidate   one-cycle pulse (fence.i), clears every valid bit
//   wish_s       processor side (secondary), DATA_SIZE data
//   wish_p       memory side (primary), LINE_SIZE data
//   hit_count    LOOKUP hits, saturating   (ICACHE_PERF_COUNTERS_EN only)
//   miss_count   LOOKUP misses, saturating (ICACHE_PERF_COUNTERS_EN only)
//
// Build option
//   ICACHE_PERF_COUNTERS_EN  adds hit_count/miss_count outputs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instruction_cache #(
    parameter int ADDR_SIZE   = 64,
    parameter int DATA_SIZE   = 32,
    parameter int LINE_SIZE   = 128,
    parameter int CACHE_LINES = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              invalidate,
    wishbone_if.secondary     wish_s,
    wishbone_if.primary       wish_p
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int OFF_W  = $clog2(LINE_SIZE / 8);
    localparam int IDX_W  = $clog2(CACHE_LINES);
    localparam int BYTE_W = $clog2(DATA_SIZE / 8);
    localparam int TAG_W  = ADDR_SIZE - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_SIZE-1:0]     addr_q, addr_d;
    logic                     ack_q, ack_d;
    logic [DATA_SIZE-1:0]     dat_q, dat_d;
    logic                     pcyc_q, pcyc_d;
    logic [ADDR_SIZE-1:0]     paddr_q, paddr_d;
    logic [CACHE_LINES-1:0]   valid_q, valid_d;
    logic                     drop_q, drop_d;   // processor gave up during refill
    logic                     inv_q, inv_d;     // invalidate seen since the miss
    logic                     fill_en;

    logic [LINE_SIZE-1:0]     data_mem [CACHE_LINES];
    logic [TAG_W-1:0]         tag_mem  [CACHE_LINES];

    logic                     req;
    logic [IDX_W-1:0]         l_idx;
    logic [TAG_W-1:0]         l_tag;
    logic [OFF_W-BYTE_W-1:0]  l_word;
    logic                     lookup_hit;

    function automatic logic [DATA_SIZE-1:0] sel_word(
        input logic [LINE_SIZE-1:0]    line,
        input logic [OFF_W-BYTE_W-1:0] w
    );
        return line[int'(w)*DATA_SIZE +: DATA_SIZE];
    endfunction

    assign req        = wish_s.cyc && wish_s.stb;
    assign l_idx      = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign l_tag      = addr_q[ADDR_SIZE-1:OFF_W+IDX_W];
    assign l_word     = addr_q[OFF_W-1:BYTE_W];
    assign lookup_hit = valid_q[l_idx] && (tag_mem[l_idx] == l_tag);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ack_d   = 1'b0;
        dat_d   = '0;
        pcyc_d  = pcyc_q;
        paddr_d = paddr_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        inv_d   = inv_q;
        fill_en = 1'b0;

        case (state_q)
            IDLE: begin
                // While ack is up the processor is still presenting the request
                // it is being answered for; ignore it so ack never repeats.
                if (req && !ack_q) begin
                    if (wish_s.we) begin
                        ack_d = 1'b1;
                    end else begin
                        addr_d  = wish_s.addr;
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (lookup_hit) begin
                    ack_d   = 1'b1;
                    dat_d   = sel_word(data_mem[l_idx], l_word);
                    state_d = IDLE;
                end else begin
                    pcyc_d  = 1'b1;
                    paddr_d = {addr_q[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                    drop_d  = 1'b0;
                    inv_d   = 1'b0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (!req) drop_d = 1'b1;
                if (wish_p.ack) begin
                    fill_en          = 1'b1;
                    pcyc_d           = 1'b0;
                    paddr_d          = '0;
                    valid_d[l_idx]   = !(inv_q || invalidate);
                    // Word is taken straight off the bus so RESPOND carries it
                    // even when the line is left invalid.
                    ack_d            = req && !drop_q;
                    dat_d            = ack_d ? sel_word(wish_p.dat_i_p, l_word) : '0;
                    state_d          = RESPOND;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (invalidate) begin
            valid_d = '0;
            if (state_q == LOOKUP || state_q == REFILL) inv_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            pcyc_q  <= 1'b0;
            paddr_q <= '0;
            valid_q <= '0;
            drop_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            pcyc_q  <= pcyc_d;
            paddr_q <= paddr_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            inv_q   <= inv_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_mem[l_idx] <= wish_p.dat_i_p;
            tag_mem[l_idx]  <= l_tag;
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_evt, miss_evt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign hit_evt  = (state_q == LOOKUP) && req && lookup_hit;
    assign miss_evt = (state_q == LOOKUP) && req && !lookup_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt)  hit_cnt_q  <= sat_inc(hit_cnt_q);
            if (miss_evt) miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign wish_s.ack     = ack_q;
    assign wish_s.dat_o_s = dat_q;
    assign wish_p.cyc     = pcyc_q;
    assign wish_p.stb     = pcyc_q;
    assign wish_p.we      = 1'b0;
    assign wish_p.sel     = '1;
    assign wish_p.tgd     = 1'b0;
    assign wish_p.addr    = paddr_q;

    logic unused_bits;
    assign unused_bits = ^{wish_s.sel, wish_s.tgd, addr_q[BYTE_W-1:0]};
endmodule

// File: tb/tb_instruction_cache.sv
`timescale 1ns/1ps

module tb_instruction_cache;
    logic clock = 1'b0;
    logic reset_n;
    logic invalidate;

    always #5 clock = ~clock;

    wishbone_if #(.ADDR_W(64), .DATA_W(32))  s_if ();
    wishbone_if #(.ADDR_W(64), .DATA_W(128)) p_if ();

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] hit_count, miss_count;
`endif

    instruction_cache dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .invalidate (invalidate),
        .wish_s     (s_if),
        .wish_p     (p_if)
`ifdef ICACHE_PERF_COUNTERS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory model: acks a line request mem_lat negedges after cyc rises.
    // Word k of the line at base B is (k+1)*0x1111_1111 ^ B[31:0].
    // ------------------------------------------------------------------
    int          mem_lat = 3;
    int          mem_cnt = 0;
    int          n_fills = 0;
    logic [63:0] last_fill = '0;

    function automatic logic [127:0] line_of(input logic [63:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = (32'h1111_1111 * (k + 1)) ^ a[31:0];
        return l;
    endfunction

    initial begin
        p_if.ack     = 1'b0;
        p_if.dat_i_p = '0;
        p_if.dat_o_s = '0;
        forever begin
            @(negedge clock);
            if (p_if.cyc && p_if.stb && !p_if.ack) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    p_if.ack     = 1'b1;
                    p_if.dat_i_p = line_of(p_if.addr);
                    n_fills++;
                    last_fill    = p_if.addr;
                end
            end else begin
                mem_cnt      = 0;
                p_if.ack     = 1'b0;
                p_if.dat_i_p = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Processor-side helpers
    // ------------------------------------------------------------------
    task automatic do_req(input logic [63:0] a, input logic we,
                          output logic [31:0] d, output int lat, output bit got);
        @(negedge clock);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.we = we; s_if.addr = a;
        lat = 0; got = 1'b0; d = '0;
        while (!got && lat < 60) begin
            @(posedge clock); #1;
            lat++;
            if (s_if.ack) begin
                got = 1'b1;
                d   = s_if.dat_o_s;
            end
        end
        @(negedge clock);
        s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
    endtask

    task automatic chk_read(input string name, input logic [63:0] a, input logic we,
                            input logic [31:0] exp_dat, input int exp_lat, input int exp_fills);
        logic [31:0] d;
        int lat, f0;
        bit got;
        f0 = n_fills;
        do_req(a, we, d, lat, got);
        chk({name, " ack"},   64'(got), 64'd1);
        chk({name, " data"},  64'(d), 64'(exp_dat));
        chk({name, " lat"},   64'(lat), 64'(exp_lat));
        chk({name, " fills"}, 64'(n_fills - f0), 64'(exp_fills));
        if (exp_fills == 1) chk({name, " fill addr"}, last_fill, a & ~64'hF);
        // one cycle later ack must be low and data zero
        @(posedge clock); #1;
        chk({name, " ack gap"}, 64'(s_if.ack), 64'd0);
        chk({name, " dat idle"}, 64'(s_if.dat_o_s), 64'd0);
    endtask

    task automatic wait_pcyc(input string name);
        int w = 0;
        while (!p_if.cyc && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        chk({name, " refill started"}, 64'(p_if.cyc), 64'd1);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [31:0] exp_dat;
        int          exp_lat;
        int          exp_fills;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] d;
        int lat, f0, w;
        bit seen_ack, seen_cyc;

        vecs[0]  = '{64'h0000_0004, 1'b0, 32'h2222_2222, 5, 1}; // cold miss
        vecs[1]  = '{64'h0000_0008, 1'b0, 32'h3333_3333, 2, 0}; // hit
        vecs[2]  = '{64'h0000_0000, 1'b0, 32'h1111_1111, 2, 0}; // hit word 0
        vecs[3]  = '{64'h0000_0400, 1'b0, 32'h1111_1511, 5, 1}; // same index, evicts
        vecs[4]  = '{64'h0000_0000, 1'b0, 32'h1111_1111, 5, 1}; // conflict refill
        vecs[5]  = '{64'h0000_000C, 1'b0, 32'h4444_4444, 2, 0}; // hit word 3
        vecs[6]  = '{64'h0000_0020, 1'b1, 32'h0000_0000, 1, 0}; // write: ack, no bus
        vecs[7]  = '{64'h0000_0020, 1'b0, 32'h1111_1131, 5, 1}; // read after write misses
        vecs[8]  = '{64'h0000_0024, 1'b0, 32'h2222_2202, 2, 0}; // hit
        vecs[9]  = '{64'h0000_1000_0000_0000, 1'b0, 32'h1111_1111, 5, 1}; // high tag bits
        vecs[10] = '{64'h0000_03F0, 1'b0, 32'h1111_12E1, 5, 1}; // last index
        vecs[11] = '{64'h0000_03FC, 1'b0, 32'h4444_47B4, 2, 0}; // last word, last index

        reset_n    = 1'b0;
        invalidate = 1'b0;
        s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
        s_if.sel = '1; s_if.tgd = 1'b0; s_if.addr = '0; s_if.dat_i_p = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset ack",   64'(s_if.ack), 64'd0);
        chk("reset dat",   64'(s_if.dat_o_s), 64'd0);
        chk("reset p cyc", 64'(p_if.cyc), 64'd0);
        chk("reset p stb", 64'(p_if.stb), 64'd0);
        chk("reset p addr", p_if.addr, 64'd0);
`ifdef ICACHE_PERF_COUNTERS_EN
        chk("reset hit_count",  64'(hit_count), 64'd0);
        chk("reset miss_count", 64'(miss_count), 64'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++)
            chk_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we,
                     vecs[i].exp_dat, vecs[i].exp_lat, vecs[i].exp_fills);

`ifdef ICACHE_PERF_COUNTERS_EN
        chk("hit_count", 64'(hit_count), 64'd5);
        chk("miss_count", 64'(miss_count), 64'd6);
`endif

        // invalidate pulse while refilling 0x10
        @(negedge clock);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.addr = 64'h10;
        wait_pcyc("inv-refill");
        chk("inv-refill p addr", p_if.addr, 64'h10);
        chk("inv-refill p we",   64'(p_if.we), 64'd0);
        chk("inv-refill p sel",  64'(p_if.sel), 64'hFFFF);
        chk("inv-refill p tgd",  64'(p_if.tgd), 64'd0);
        @(negedge clock); invalidate = 1'b1;
        @(negedge clock); invalidate = 1'b0;
        w = 0; seen_ack = 1'b0; d = '0;
        while (!seen_ack && w < 20) begin
            @(posedge clock); #1; w++;
            if (s_if.ack) begin seen_ack = 1'b1; d = s_if.dat_o_s; end
        end
        chk("inv-refill ack",  64'(seen_ack), 64'd1);
        chk("inv-refill data", 64'(d), 64'h1111_1101);
        @(negedge clock); s_if.cyc = 1'b0; s_if.stb = 1'b0;
        chk_read("inv-refill reread", 64'h10,  1'b0, 32'h1111_1101, 5, 1);
        chk_read("inv-all reread",    64'h3FC, 1'b0, 32'h4444_47B4, 5, 1);

        // request dropped in LOOKUP: no ack, no refill
        f0 = n_fills;
        @(negedge clock);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.addr = 64'h60;
        @(negedge clock);
        s_if.cyc = 1'b0; s_if.stb = 1'b0;
        seen_ack = 1'b0; seen_cyc = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            seen_ack |= s_if.ack; seen_cyc |= p_if.cyc;
        end
        chk("drop-lookup ack", 64'(seen_ack), 64'd0);
        chk("drop-lookup cyc", 64'(seen_cyc), 64'd0);
        chk("drop-lookup fills", 64'(n_fills - f0), 64'd0);

        // request dropped in REFILL: line still installed, no ack
        f0 = n_fills;
        @(negedge clock);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.addr = 64'h70;
        wait_pcyc("drop-refill");
        @(negedge clock);
        s_if.cyc = 1'b0; s_if.stb = 1'b0;
        seen_ack = 1'b0; w = 0;
        while (n_fills == f0 && w < 20) begin
            @(posedge clock); #1; w++;
            seen_ack |= s_if.ack;
        end
        chk("drop-refill fills", 64'(n_fills - f0), 64'd1);
        repeat (4) begin
            @(posedge clock); #1;
            seen_ack |= s_if.ack;
        end
        chk("drop-refill ack", 64'(seen_ack), 64'd0);
        chk_read("drop-refill hit", 64'h74, 1'b0, 32'h2222_2252, 2, 0);

        // invalidate together with a LOOKUP hit: hit honoured, line gone after
        @(negedge clock);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.addr = 64'h78;
        @(negedge clock);
        invalidate = 1'b1;
        @(posedge clock); #1;
        chk("inv-hit ack",  64'(s_if.ack), 64'd1);
        chk("inv-hit data", 64'(s_if.dat_o_s), 64'h3333_3343);
        @(negedge clock);
        invalidate = 1'b0; s_if.cyc = 1'b0; s_if.stb = 1'b0;
        chk_read("inv-hit reread", 64'h78, 1'b0, 32'h3333_3343, 5, 1);

        // asynchronous reset in the middle of a refill
        mem_lat = 50;
        @(negedge clock);
        s_if.cyc = 1'b1; s_if.stb = 1'b1; s_if.addr = 64'h50;
        wait_pcyc("rst-refill");
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst-refill p cyc",  64'(p_if.cyc), 64'd0);
        chk("rst-refill p stb",  64'(p_if.stb), 64'd0);
        chk("rst-refill p addr", p_if.addr, 64'd0);
        chk("rst-refill ack",    64'(s_if.ack), 64'd0);
        s_if.cyc = 1'b0; s_if.stb = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mem_lat = 3;
        chk_read("rst reread",      64'h50, 1'b0, 32'h1111_1141, 5, 1);
        chk_read("rst lost line",   64'h74, 1'b0, 32'h2222_2252, 5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
